// File: rtl/cmp_pkg.sv
// Shared types for the iterative magnitude comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Result vector ordering is {lt, gt, eq}
    localparam logic [2:0] CMP_LT   = 3'b100;
    localparam logic [2:0] CMP_GT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/cmp_digit.sv
// Single-digit unsigned magnitude compare.
// Latency: combinational.
// Backpressure: none.
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    output logic             lt_d,
    output logic             gt_d
);

    assign lt_d = (a_d < b_d);
    assign gt_d = (a_d > b_d);

endmodule

// File: rtl/seq_mag_comparator.sv
// Iterative MSB-first magnitude comparator, DIGIT bits per cycle, optional signed mode.
// Latency: k+1 cycles from accepted start to done, k = digits examined (1..N, or N without early exit).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted with no bubble.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int N         = WIDTH / DIGIT,
    localparam int CNT_W     = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [CNT_W-1:0] cycles
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("seq_mag_comparator: WIDTH must be a multiple of DIGIT");
    end

    cmp_state_t       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [2:0]       res_q,    res_d;
    logic [1:0]       diff_q,   diff_d;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_lt;
    logic             dig_gt;
    logic [1:0]       first_diff;

    assign dig_a = a_q[idx_q*DIGIT +: DIGIT];
    assign dig_b = b_q[idx_q*DIGIT +: DIGIT];

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d  (dig_a),
        .b_d  (dig_b),
        .lt_d (dig_lt),
        .gt_d (dig_gt)
    );

    // The first differing digit decides the result; later digits never overwrite it
    assign first_diff = (diff_q != 2'b00) ? diff_q : {dig_lt, dig_gt};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        res_d    = res_q;
        diff_d   = diff_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto offset binary
                    a_d     = signed_mode ? (a ^ MSB_MASK) : a;
                    b_d     = signed_mode ? (b ^ MSB_MASK) : b;
                    idx_d   = IDX_W'(N - 1);
                    cnt_d   = '0;
                    res_d   = CMP_NONE;
                    diff_d  = 2'b00;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if ((EARLY_EXIT != 0) && (dig_lt || dig_gt)) begin
                    res_d    = dig_lt ? CMP_LT : CMP_GT;
                    cycles_d = CNT_W'(cnt_q + 1'b1);
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    res_d    = (first_diff == 2'b00) ? CMP_EQ : {first_diff, 1'b0};
                    cycles_d = CNT_W'(cnt_q + 1'b1);
                    state_d  = DONE;
                end else begin
                    idx_d  = idx_q - 1'b1;
                    diff_d = first_diff;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            res_q    <= CMP_NONE;
            diff_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign {lt, gt, eq}  = res_q;
    assign cycles        = cycles_q;

endmodule
